// File: rtl/riscv_alu_pkg.sv
// Shared types and constants for the ALU arbiter.
// Optional feature macro: RISCV_ALU_ARB_RR_EN (round-robin arbitration).
package riscv_alu_pkg;

  localparam int ALU_OP_W   = 4;
  localparam int ALU_DATA_W = 32;

  // Requester index: 0 = integer execute stage, 1 = address/branch-compare sequencer
  typedef logic req_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } res_state_t;

endpackage

// File: rtl/riscv_alu_arb_grant.sv
// Grant selection for the two ALU requesters, with grant lock while the
// result register cannot accept.
// Macro RISCV_ALU_ARB_RR_EN: round-robin on contention; otherwise requester 0 wins.
module riscv_alu_arb_grant
  import riscv_alu_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    req0_valid_i,
  input  logic    req1_valid_i,
  input  logic    can_accept_i,
  input  logic    xfer_i,
  output req_id_t grant_id_o,
  output logic    grant_vld_o
);

  logic    r_lock_vld;
  req_id_t r_lock_id;
  req_id_t w_prio_id;

`ifdef RISCV_ALU_ARB_RR_EN
  req_id_t r_last;

  // Remember who was served last; reset to 1 so requester 0 wins first contention
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
    end else if (xfer_i) begin
      r_last <= grant_id_o;
    end
  end

  assign w_prio_id = ~r_last;
`else
  assign w_prio_id = 1'b0;
`endif

  // Grant: a lock pins the requester that was waiting on a full register
  always_comb begin
    grant_id_o  = 1'b0;
    grant_vld_o = req0_valid_i | req1_valid_i;
    if (r_lock_vld) begin
      grant_id_o  = r_lock_id;
      grant_vld_o = r_lock_id ? req1_valid_i : req0_valid_i;
    end else if (req0_valid_i && req1_valid_i) begin
      grant_id_o = w_prio_id;
    end else if (req1_valid_i) begin
      grant_id_o = 1'b1;
    end
  end

  // Lock a grant that could not transfer; release on its transfer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock_vld <= 1'b0;
      r_lock_id  <= 1'b0;
    end else if (xfer_i) begin
      r_lock_vld <= 1'b0;
    end else if (grant_vld_o && !can_accept_i) begin
      r_lock_vld <= 1'b1;
      r_lock_id  <= grant_id_o;
    end
  end

endmodule

// File: rtl/riscv_alu_arbiter.sv
// Shares one ALU between the execute stage (req0) and the address/branch
// sequencer (req1). Operands are muxed combinationally to the ALU and the
// result is captured into a one-entry output register with valid/ready.
// Macro RISCV_ALU_ARB_RR_EN selects round-robin instead of fixed priority.
module riscv_alu_arbiter
  import riscv_alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [OP_W-1:0]   req1_op_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic              req1_ready_o,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_p_i,
  output logic              res_valid_o,
  output logic              res_id_o,
  output logic [DATA_W-1:0] res_p_o,
  input  logic              res_ready_i
);

  res_state_t        r_state;
  res_state_t        w_state_nxt;
  req_id_t           r_res_id;
  logic [DATA_W-1:0] r_res_p;
  req_id_t           w_grant_id;
  logic              w_grant_vld;
  logic              w_can_accept;
  logic              w_xfer;

  assign w_can_accept = (r_state == EMPTY) || res_ready_i;
  assign w_xfer       = w_grant_vld && w_can_accept;

  riscv_alu_arb_grant u_grant (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req1_valid_i (req1_valid_i),
    .can_accept_i (w_can_accept),
    .xfer_i       (w_xfer),
    .grant_id_o   (w_grant_id),
    .grant_vld_o  (w_grant_vld)
  );

  assign req0_ready_o = w_xfer && (w_grant_id == 1'b0);
  assign req1_ready_o = w_xfer && (w_grant_id == 1'b1);

  // Operand mux to the ALU; idle lines are held at zero
  always_comb begin
    alu_op_o = '0;
    alu_a_o  = '0;
    alu_b_o  = '0;
    if (w_grant_vld) begin
      if (w_grant_id == 1'b1) begin
        alu_op_o = req1_op_i;
        alu_a_o  = req1_a_i;
        alu_b_o  = req1_b_i;
      end else begin
        alu_op_o = req0_op_i;
        alu_a_o  = req0_a_i;
        alu_b_o  = req0_b_i;
      end
    end
  end

  // Output register state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a request transfer always leaves the register full
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_xfer) w_state_nxt = FULL;
      FULL: begin
        if (w_xfer) begin
          w_state_nxt = FULL;
        end else if (res_ready_i) begin
          w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Capture the ALU result and issuing requester on each request transfer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_res_p  <= '0;
      r_res_id <= 1'b0;
    end else if (w_xfer) begin
      r_res_p  <= alu_p_i;
      r_res_id <= w_grant_id;
    end
  end

  assign res_valid_o = (r_state == FULL);
  assign res_p_o     = r_res_p;
  assign res_id_o    = r_res_id;

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Directed bench for riscv_alu_arbiter with a result scoreboard.
// Expectations follow RISCV_ALU_ARB_RR_EN when it is defined.
module tb_riscv_alu_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic [3:0]  req0_op_i, req1_op_i;
  logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic        req0_ready_o, req1_ready_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o, alu_p_i;
  logic        res_valid_o, res_id_o;
  logic [31:0] res_p_o;
  logic        res_ready_i;

  int checks   = 0;
  int failures = 0;

  logic [32:0] sb_q[$];
  logic        exp_full;
  logic [31:0] last_p;
  logic        last_id;

  always #5 clk_i = ~clk_i;

  // Stand-in ALU: sum of operands plus opcode
  assign alu_p_i = alu_a_o + alu_b_o + {28'd0, alu_op_o};

  riscv_alu_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_op_i    (req0_op_i),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_op_i    (req1_op_i),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .req1_ready_o (req1_ready_o),
    .alu_op_o     (alu_op_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_p_i      (alu_p_i),
    .res_valid_o  (res_valid_o),
    .res_id_o     (res_id_o),
    .res_p_o      (res_p_o),
    .res_ready_i  (res_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of directed stimulus; eg is the expected grant (-1 = none)
  task automatic step(input string tag, input logic v0, input logic v1,
                      input logic rr, input int eg);
    logic        cacc, xfer;
    logic [3:0]  eo;
    logic [31:0] ea, eb, ep;
    logic [32:0] ent;
    req0_valid_i = v0;
    req1_valid_i = v1;
    res_ready_i  = rr;
    @(negedge clk_i);
    cacc = !exp_full || rr;
    xfer = (eg >= 0) && cacc;
    chk({tag, ".rdy0"}, {31'd0, req0_ready_o}, {31'd0, xfer && eg == 0});
    chk({tag, ".rdy1"}, {31'd0, req1_ready_o}, {31'd0, xfer && eg == 1});
    eo = 4'd0; ea = 32'd0; eb = 32'd0;
    if (eg == 0) begin eo = req0_op_i; ea = req0_a_i; eb = req0_b_i; end
    if (eg == 1) begin eo = req1_op_i; ea = req1_a_i; eb = req1_b_i; end
    chk({tag, ".alu_op"}, {28'd0, alu_op_o}, {28'd0, eo});
    chk({tag, ".alu_a"}, alu_a_o, ea);
    chk({tag, ".alu_b"}, alu_b_o, eb);
    ep = ea + eb + {28'd0, eo};
    if (xfer) sb_q.push_back({eg == 1, ep});
    @(posedge clk_i);
    #1;
    if (xfer) begin
      exp_full = 1'b1;
      if (eg == 0) begin
        req0_op_i = req0_op_i + 4'd1; req0_a_i = req0_a_i * 3 + 7; req0_b_i = req0_b_i + 5;
      end else begin
        req1_op_i = req1_op_i + 4'd3; req1_a_i = req1_a_i + 32'h111; req1_b_i = req1_b_i ^ 32'h5a;
      end
    end else if (rr) begin
      exp_full = 1'b0;
    end
    chk({tag, ".res_valid"}, {31'd0, res_valid_o}, {31'd0, exp_full});
    if (xfer) begin
      ent = sb_q.pop_front();
      last_id = ent[32];
      last_p  = ent[31:0];
    end
    if (exp_full) begin
      chk({tag, ".res_id"}, {31'd0, res_id_o}, {31'd0, last_id});
      chk({tag, ".res_p"}, res_p_o, last_p);
    end
  endtask

  initial begin
    exp_full = 1'b0; last_p = 32'd0; last_id = 1'b0;
    rst_i = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; res_ready_i = 1'b0;
    req0_op_i = 4'b0100; req0_a_i = 32'd24;   req0_b_i = 32'd10;
    req1_op_i = 4'd9;    req1_a_i = 32'd1000; req1_b_i = 32'd77;
    #2;
    chk("reset.res_valid", {31'd0, res_valid_o}, 32'd0);
    chk("reset.res_p", res_p_o, 32'd0);
    chk("reset.res_id", {31'd0, res_id_o}, 32'd0);
    chk("reset.alu_a", alu_a_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Single requester 0: op=4, a=24, b=10 -> result 38
    step("single0", 1'b1, 1'b0, 1'b1, 0);
    chk("single0.p38", res_p_o, 32'd38);

    // Contention with res_ready_i=1
`ifdef RISCV_ALU_ARB_RR_EN
    step("rr_c0", 1'b1, 1'b1, 1'b1, 1);
    step("rr_c1", 1'b1, 1'b1, 1'b1, 0);
    step("rr_c2", 1'b1, 1'b1, 1'b1, 1);
    step("rr_c3", 1'b1, 1'b1, 1'b1, 0);
`else
    step("fp_c0", 1'b1, 1'b1, 1'b1, 0);
    step("fp_c1", 1'b1, 1'b1, 1'b1, 0);
    step("fp_c2", 1'b1, 1'b1, 1'b1, 0);
    step("fp_c3", 1'b1, 1'b1, 1'b1, 0);
`endif

    // FULL and stalled for 3 cycles; req1 alone gets locked
    step("stall0", 1'b0, 1'b1, 1'b0, 1);
    step("stall1", 1'b0, 1'b1, 1'b0, 1);
    step("stall2", 1'b0, 1'b1, 1'b0, 1);
    step("lock_r0", 1'b1, 1'b1, 1'b0, 1);
    // Release: back-to-back load while FULL, locked requester wins
    step("lock_rel", 1'b1, 1'b1, 1'b1, 1);
    step("b2b", 1'b1, 1'b0, 1'b1, 0);
    step("drain", 1'b0, 1'b0, 1'b1, -1);
    step("idle", 1'b0, 1'b0, 1'b1, -1);

    // Reset mid-stream while FULL with req1 locked
    step("pre_rst0", 1'b1, 1'b0, 1'b0, 0);
    step("pre_rst1", 1'b0, 1'b1, 1'b0, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_mid.res_valid", {31'd0, res_valid_o}, 32'd0);
    chk("rst_mid.res_p", res_p_o, 32'd0);
    chk("rst_mid.res_id", {31'd0, res_id_o}, 32'd0);
    sb_q.delete();
    exp_full = 1'b0;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    step("post_rst_c0", 1'b1, 1'b1, 1'b1, 0);
`ifdef RISCV_ALU_ARB_RR_EN
    step("post_rst_c1", 1'b1, 1'b1, 1'b1, 1);
`else
    step("post_rst_c1", 1'b1, 1'b1, 1'b1, 0);
`endif
    step("final_idle", 1'b0, 1'b0, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_alu_arbiter.md
# riscv_alu_arbiter

Shares the single `riscv_alu` instance between two requesters: requester 0 is the integer execute stage, and requester 1 is the address/branch-compare sequencer. The block grants one requester per cycle and drives the ALU operand and opcode lines from that requester. It captures the ALU result into a one-entry output register, which returns the result with the requester ID under a valid/ready handshake. The block sits between the execute-stage issue logic and the ALU; the ALU is instantiated in the parent.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 4, ALU opcode width (passed through unmodified)
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset; asynchronous, active-high
- req0_valid_i  in  1  requester 0 has an operation
- req0_op_i  in  OP_W  requester 0 opcode
- req0_a_i  in  DATA_W  requester 0 operand A
- req0_b_i  in  DATA_W  requester 0 operand B
- req0_ready_o  out  1  requester 0 operation accepted this cycle
- req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_ready_o: same as requester 0, for requester 1
- alu_op_o  out  OP_W  opcode to the ALU
- alu_a_o  out  DATA_W  operand A to the ALU
- alu_b_o  out  DATA_W  operand B to the ALU
- alu_p_i  in  DATA_W  combinational ALU result
- res_valid_o  out  1  result register holds a result
- res_id_o  out  1  requester that issued the held result
- res_p_o  out  DATA_W  held result
- res_ready_i  in  1  consumer takes the result

## Operation
- Handshake rules:
  - A request transfers when reqN_valid_i && reqN_ready_o.
  - Once valid is raised, the requester holds valid and payload stable until the transfer.
  - A result transfers when res_valid_o && res_ready_i.
- Output register states: EMPTY and FULL.
  - EMPTY→FULL on a request transfer.
  - FULL→EMPTY on a result transfer with no request transfer.
  - FULL→FULL on a simultaneous result transfer and request transfer, which gives back-to-back throughput.
- can_accept = EMPTY || res_ready_i.
- Grant selection:
  - One valid requester: it gets the grant.
  - Both valid: priority per Configuration.
  - Neither valid: no grant.
- Grant lock: if a requester is granted while can_accept=0, lock_q records it. The grant stays on that requester until its transfer, even if the other requester raises valid or the priority pointer would favour it.
- reqN_ready_o = (grant==N) && can_accept. At most one ready is high per cycle.
- ALU drive:
  - alu_op_o/alu_a_o/alu_b_o come from the granted requester's inputs through a combinational mux.
  - With no grant, all three are zero.
- On a request transfer, the block captures alu_p_i into res_p_o and the granted index into res_id_o.
- Widths: the result is taken as DATA_W bits with no extension or truncation. The opcode is opaque to this block.
- Reset, applied asynchronously:
  - res_valid_o=0, res_p_o=0, res_id_o=0.
  - Lock cleared; priority pointer set so requester 0 wins the first contention.
  - A request in flight at reset is dropped; requesters re-present it after reset.

## Timing
- Request accepted at edge N; result visible on res_* after edge N (latency 1 cycle).
- Sustained throughput is 1 operation per cycle while res_ready_i=1.
- res_ready_i=0 with FULL: both reqN_ready_o=0; res_* held stable.
- reqN_ready_o, alu_*_o and the grant are combinational from inputs and state. The ALU path is valid-mux → ALU → result flop, all in one cycle.
- All flops update on the rising edge of clk_i.

## Configuration
- RISCV_ALU_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant pointer updates on every request transfer.
  - On contention, the requester not served last wins.
- Not defined: fixed priority. Requester 0 always wins contention; the pointer flop is not built.
- Grant lock behaviour is identical in both modes.

## Structure
- Package riscv_alu_pkg holds:
  - ALU_OP_W and ALU_DATA_W constants
  - requester-ID typedef (1 bit)
  - output-register state enum {EMPTY, FULL}
- Sub-module riscv_alu_arb_grant contains grant selection, lock and pointer, and outputs the grant index and grant-valid.
- The top level contains the operand mux, the result register and the ready logic.

## Test plan
- Only req0 valid, op=4'b0100, a=24, b=10, res_ready_i=1:
  - req0_ready_o=1 same cycle; alu_* driven with those values.
  - res_valid_o=1, res_id_o=0, res_p_o=alu_p_i next cycle.
- Both valid every cycle, res_ready_i=1:
  - RR_EN defined: res_id_o alternates 0,1,0,1.
  - Not defined: res_id_o stays 0 and req1 is starved.
- FULL with res_ready_i=0 for 3 cycles:
  - Both readies are 0; res_p_o and res_id_o are unchanged.
  - req1 alone valid: it is locked and still wins when req0 rises before release.
- Back-to-back transfer with res_ready_i=1 while FULL: new result loads the same edge; res_valid_o stays 1 with no bubble.
- Assert rst_i mid-stream while FULL: res_valid_o/res_p_o/res_id_o go to 0 immediately; first contention after reset grants req0.
- No valids: alu_op_o/alu_a_o/alu_b_o=0 and both readies are 0.
